// File: rtl/cr_kme_ram_fifo_arb.sv
// Round-robin, packet-locked arbiter for the shared KME RAM FIFO write port.
// A single output register stage feeds the FIFO at up to one beat per cycle.
// The FIFO's uncorrectable-ECC pulse is also latched into a sticky status bit.
module cr_kme_ram_fifo_arb #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DW       = 71,
    parameter int unsigned LAST_BIT = 70,
    localparam int unsigned IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       fifo_in,
    output logic                fifo_in_valid,
    input  logic                fifo_in_stall,
    input  logic                fifo_mbe,
    input  logic                mbe_clr,
    output logic                mbe_sticky,
    output logic [IW-1:0]       grant_id,
    output logic                lock
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            out_vld_q, out_vld_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            mbe_q, mbe_d;

    logic            drain, load, have, accept, last;
    logic [IW-1:0]   sel, cand;
    logic [DW-1:0]   sel_data;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] x);
        return (x == IW'(N_REQ - 1)) ? '0 : x + IW'(1);
    endfunction

    assign drain = out_vld_q & ~fifo_in_stall;
    assign load  = ~out_vld_q | drain;

    // Requester selection: locked owner, or first valid requester from rr_q onward
    always_comb begin
        sel  = grant_q;
        have = 1'b0;
        cand = '0;
        if (state_q == StLocked) begin
            have = req_valid[grant_q];
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = IW'((32'(rr_q) + k) % N_REQ);
                if (!have && req_valid[cand]) begin
                    sel  = cand;
                    have = 1'b1;
                end
            end
        end
    end

    assign sel_data = req_data[32'(sel) * DW +: DW];
    assign last     = sel_data[LAST_BIT];
    // Nothing is accepted while in reset so a beat is never lost into a cleared register
    assign accept   = load & have & ~rst;

    // Ready is a one-hot strobe to the selected requester only
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    // Next-state for the output stage, lock FSM, round-robin pointer and ECC sticky bit
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        mbe_d      = fifo_mbe | (mbe_q & ~mbe_clr);

        if (load) begin
            out_vld_d = accept;
        end
        if (accept) begin
            out_data_d = sel_data;
            unique case (state_q)
                StIdle: begin
                    if (last) begin
                        rr_d = rr_next(sel);
                    end else begin
                        state_d = StLocked;
                        grant_d = sel;
                    end
                end
                StLocked: begin
                    if (last) begin
                        state_d = StIdle;
                        rr_d    = rr_next(grant_q);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_q       <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            mbe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            mbe_q      <= mbe_d;
        end
    end

    assign fifo_in_valid = drain;
    assign fifo_in       = out_data_q;
    assign mbe_sticky    = mbe_q;
    assign grant_id      = grant_q;
    assign lock          = (state_q == StLocked);

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_no_wr_on_stall : assert property (@(posedge clk) disable iff (rst)
        !(fifo_in_valid && fifo_in_stall));
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold
        a_req_hold : assert property (@(posedge clk) disable iff (rst)
            req_valid[i] && !req_ready[i] |=>
            req_valid[i] && $stable(req_data[i*DW +: DW]));
    end
`endif

endmodule

// File: tb/tb_cr_kme_ram_fifo_arb.sv
// Directed bench for cr_kme_ram_fifo_arb: reset, round-robin order, packet lock,
// stall hold, sticky ECC bit and reset while locked.
module tb_cr_kme_ram_fifo_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 71;

    typedef logic [DW-1:0] vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    vec_t            fifo_in;
    logic            fifo_in_valid;
    logic            fifo_in_stall;
    logic            fifo_mbe;
    logic            mbe_clr;
    logic            mbe_sticky;
    logic [1:0]      grant_id;
    logic            lock;

    vec_t rd [N];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    cr_kme_ram_fifo_arb #(
        .N_REQ    (N),
        .DW       (DW),
        .LAST_BIT (70)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_in       (fifo_in),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_stall (fifo_in_stall),
        .fifo_mbe      (fifo_mbe),
        .mbe_clr       (mbe_clr),
        .mbe_sticky    (mbe_sticky),
        .grant_id      (grant_id),
        .lock          (lock)
    );

    function automatic vec_t mk(input logic last, input logic [7:0] tag);
        return {last, 62'd0, tag};
    endfunction

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    vec_t prev;

    initial begin
        rst           = 1'b1;
        req_valid     = 4'hF;
        fifo_in_stall = 1'b0;
        fifo_mbe      = 1'b0;
        mbe_clr       = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = mk(1'b1, 8'(8'h10 + i));

        // 1: reset with all requesters valid
        tick();
        settle();
        chk("rst_ready", DW'(req_ready), DW'(4'b0000));
        chk("rst_fvalid", DW'(fifo_in_valid), DW'(1'b0));
        chk("rst_mbe", DW'(mbe_sticky), DW'(1'b0));
        chk("rst_lock", DW'(lock), DW'(1'b0));
        chk("rst_fifo_in", fifo_in, '0);
        tick();
        rst = 1'b0;
        settle();

        // 2: single-beat packets, grants 0,1,2,3,0; req0 has a second beat
        for (int c = 0; c < 5; c++) begin
            chk("rr_ready", DW'(req_ready), DW'(4'b0001 << (c % 4)));
            if (c > 0) begin
                chk("rr_fvalid", DW'(fifo_in_valid), DW'(1'b1));
                chk("rr_data", fifo_in, prev);
            end
            prev = rd[c % 4];
            tick();
            if (c == 0) rd[0] = mk(1'b1, 8'h18);
            else req_valid[c % 4] = 1'b0;
            settle();
        end
        chk("rr_tail_valid", DW'(fifo_in_valid), DW'(1'b1));
        chk("rr_tail_data", fifo_in, mk(1'b1, 8'h18));
        tick();
        settle();
        chk("rr_idle_valid", DW'(fifo_in_valid), DW'(1'b0));

        // 3: req1 3-beat packet while req0/req2 wait (rr pointer is at 1)
        rd[0] = mk(1'b1, 8'h20);
        rd[2] = mk(1'b1, 8'h22);
        rd[1] = mk(1'b0, 8'h31);
        req_valid = 4'b0111;
        settle();
        chk("pk_ready0", DW'(req_ready), DW'(4'b0010));
        tick();
        rd[1] = mk(1'b0, 8'h32);
        settle();
        chk("pk_lock1", DW'(lock), DW'(1'b1));
        chk("pk_gid1", DW'(grant_id), DW'(2'd1));
        chk("pk_ready1", DW'(req_ready), DW'(4'b0010));
        chk("pk_data1", fifo_in, mk(1'b0, 8'h31));
        tick();
        rd[1] = mk(1'b1, 8'h33);
        settle();
        chk("pk_lock2", DW'(lock), DW'(1'b1));
        chk("pk_ready2", DW'(req_ready), DW'(4'b0010));
        chk("pk_data2", fifo_in, mk(1'b0, 8'h32));
        tick();
        req_valid[1] = 1'b0;
        settle();
        chk("pk_unlock", DW'(lock), DW'(1'b0));
        chk("pk_ready3", DW'(req_ready), DW'(4'b0100));
        chk("pk_data3", fifo_in, mk(1'b1, 8'h33));
        tick();
        req_valid[2] = 1'b0;
        settle();
        chk("pk_ready4", DW'(req_ready), DW'(4'b0001));
        chk("pk_data4", fifo_in, mk(1'b1, 8'h22));
        tick();
        req_valid[0] = 1'b0;
        settle();
        chk("pk_data5", fifo_in, mk(1'b1, 8'h20));
        chk("pk_fvalid5", DW'(fifo_in_valid), DW'(1'b1));

        // 4: req3 3-beat packet with a 5-cycle stall after the second beat
        tick();
        rd[3] = mk(1'b0, 8'h41);
        req_valid[3] = 1'b1;
        settle();
        chk("st_ready0", DW'(req_ready), DW'(4'b1000));
        tick();
        rd[3] = mk(1'b0, 8'h42);
        settle();
        chk("st_data1", fifo_in, mk(1'b0, 8'h41));
        chk("st_ready1", DW'(req_ready), DW'(4'b1000));
        tick();
        rd[3] = mk(1'b1, 8'h43);
        fifo_in_stall = 1'b1;
        settle();
        for (int c = 0; c < 5; c++) begin
            chk("st_hold_ready", DW'(req_ready), DW'(4'b0000));
            chk("st_hold_data", fifo_in, mk(1'b0, 8'h42));
            chk("st_hold_fvalid", DW'(fifo_in_valid), DW'(1'b0));
            if (c < 4) begin
                tick();
                settle();
            end
        end
        tick();
        fifo_in_stall = 1'b0;
        settle();
        chk("st_rel_ready", DW'(req_ready), DW'(4'b1000));
        chk("st_rel_data", fifo_in, mk(1'b0, 8'h42));
        chk("st_rel_fvalid", DW'(fifo_in_valid), DW'(1'b1));
        tick();
        req_valid[3] = 1'b0;
        settle();
        chk("st_last_data", fifo_in, mk(1'b1, 8'h43));
        chk("st_last_fvalid", DW'(fifo_in_valid), DW'(1'b1));
        chk("st_last_lock", DW'(lock), DW'(1'b0));
        tick();
        settle();
        chk("st_empty", DW'(fifo_in_valid), DW'(1'b0));

        // 5: sticky ECC bit, set wins over clear
        fifo_mbe = 1'b1;
        mbe_clr  = 1'b1;
        tick();
        fifo_mbe = 1'b0;
        mbe_clr  = 1'b0;
        settle();
        chk("mbe_set_wins", DW'(mbe_sticky), DW'(1'b1));
        tick();
        settle();
        chk("mbe_holds", DW'(mbe_sticky), DW'(1'b1));
        mbe_clr = 1'b1;
        tick();
        mbe_clr = 1'b0;
        settle();
        chk("mbe_cleared", DW'(mbe_sticky), DW'(1'b0));

        // 6: move rr pointer to 3, lock on req3, then reset mid-packet
        rd[2] = mk(1'b1, 8'h51);
        req_valid = 4'b0100;
        settle();
        chk("rl_ready0", DW'(req_ready), DW'(4'b0100));
        tick();
        req_valid[2] = 1'b0;
        rd[3] = mk(1'b0, 8'h61);
        req_valid[3] = 1'b1;
        settle();
        chk("rl_ready1", DW'(req_ready), DW'(4'b1000));
        chk("rl_data1", fifo_in, mk(1'b1, 8'h51));
        tick();
        rd[3] = mk(1'b0, 8'h62);
        rd[0] = mk(1'b1, 8'h70);
        rd[1] = mk(1'b1, 8'h71);
        rd[2] = mk(1'b1, 8'h72);
        req_valid = 4'hF;
        settle();
        chk("rl_lock", DW'(lock), DW'(1'b1));
        chk("rl_gid", DW'(grant_id), DW'(2'd3));
        chk("rl_ready2", DW'(req_ready), DW'(4'b1000));
        rst = 1'b1;
        settle();
        chk("rl_rst_ready", DW'(req_ready), DW'(4'b0000));
        tick();
        rst = 1'b0;
        settle();
        chk("rl_post_lock", DW'(lock), DW'(1'b0));
        chk("rl_post_fvalid", DW'(fifo_in_valid), DW'(1'b0));
        chk("rl_post_gid", DW'(grant_id), DW'(2'd0));
        chk("rl_post_ready", DW'(req_ready), DW'(4'b0001));
        tick();
        settle();
        chk("rl_post_data", fifo_in, mk(1'b1, 8'h70));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
